// File: rtl/serial_rx.sv
// serial_rx: 8-bit async serial receiver with 2-of-3 centre voting and a one-deep valid/ready output.
// Define SERIAL_RX_PARITY_EN to expect an even-parity bit before the stop bit and expose parity_err.
module serial_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
`ifdef SERIAL_RX_PARITY_EN
    output logic       parity_err,
`endif
    input  logic       err_clr,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] SAMPLE_A = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] SAMPLE_B = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] VOTE_AT  = CW'(CLKS_PER_BIT / 2 + 1);

`ifdef SERIAL_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state;
    logic            rx_meta;
    logic            rx_sync;
    logic            rx_prev;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            s0;
    logic            s1;
    logic            vote;

    // The third sample is the live synchronised value at the vote point.
    assign vote = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            s0        <= 1'b1;
            s1        <= 1'b1;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            busy      <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;

            if (valid && ready)
                valid <= 1'b0;

            // Clears come first so an error set later in this cycle wins.
            if (err_clr) begin
                frame_err <= 1'b0;
                overrun   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
                parity_err <= 1'b0;
`endif
            end

            if (state != IDLE) begin
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                if (cnt == SAMPLE_A)
                    s0 <= rx_sync;
                if (cnt == SAMPLE_B)
                    s1 <= rx_sync;
            end

            case (state)
                IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == VOTE_AT && vote) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == LAST) begin
                        state   <= DATA;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (cnt == VOTE_AT)
                        shift <= {vote, shift[7:1]};
                    if (cnt == LAST) begin
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                PARITY: begin
                    if (cnt == VOTE_AT && (vote ^ (^shift)))
                        parity_err <= 1'b1;
                    if (cnt == LAST)
                        state <= STOP;
                end
`endif
                STOP: begin
                    // Leave half a bit early so the next start edge is caught cleanly.
                    if (cnt == VOTE_AT) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!vote) begin
                            frame_err <= 1'b1;
                        end else if (!valid || ready) begin
                            data  <= shift;
                            valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
